// File: rtl/game_phase_sequencer.sv
// Escape-room game phase sequencer: walks the puzzle phases with inter-phase dwell,
// and tracks a saturating stability score that can end the game early.
module game_phase_sequencer #(
  parameter int NUM_PHASES      = 4,
  parameter int STAB_INIT       = 5,
  parameter int STAB_MAX        = 9,
  parameter int TRANS_CYCLES    = 3,
  parameter bit EVENT_FREEZE    = 1'b1,
  parameter bit TIMER_PER_PHASE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_pulse,
  input  logic [NUM_PHASES-1:0] phase_clear,
  input  logic                  time_out,
  input  logic                  puzzle_fail,
  input  logic                  event_fail,
  input  logic                  recover,
  input  logic                  event_active,
  output logic [3:0]            state_id,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic [3:0]            stability,
  output logic                  game_enable,
  output logic                  timer_reset,
  output logic                  game_clear,
  output logic                  game_over,
  output logic                  in_transition
);

  localparam int         CNT_W      = (TRANS_CYCLES > 1) ? $clog2(TRANS_CYCLES) : 1;
  localparam logic [3:0] STAB_INIT4 = 4'(STAB_INIT);
  localparam logic [3:0] STAB_MAX4  = 4'(STAB_MAX);
  localparam logic [3:0] LAST_PHASE = 4'(NUM_PHASES);

  typedef enum logic [2:0] {S_IDLE, S_PHASE, S_TRANS, S_CLEAR, S_OVER} state_e;

  state_e           state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [3:0]       stab_q, stab_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timer_q, timer_d;
  logic             fail_only, recover_only, clear_hit;

  // phase_q holds the active phase, and the phase just cleared while dwelling.
  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_onehot
      assign phase_onehot[gi] = (state_q == S_PHASE) && (phase_q == 4'(gi + 1));
    end
  endgenerate

  assign clear_hit    = |(phase_clear & phase_onehot);
  assign fail_only    = (puzzle_fail | event_fail) & ~recover;
  assign recover_only = recover & ~(puzzle_fail | event_fail);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= 4'd0;
      stab_q  <= STAB_INIT4;
      cnt_q   <= '0;
      timer_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    stab_d  = stab_q;
    cnt_d   = cnt_q;
    timer_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          state_d = S_PHASE;
          phase_d = 4'd1;
          stab_d  = STAB_INIT4;
          timer_d = 1'b1;
        end
      end
      S_PHASE: begin
        if (fail_only && stab_q != 4'd0) begin
          stab_d = stab_q - 4'd1;
        end else if (recover_only && stab_q < STAB_MAX4) begin
          stab_d = stab_q + 4'd1;
        end
        // Losing beats solving when both land in the same cycle.
        if (time_out || (fail_only && stab_q <= 4'd1)) begin
          state_d = S_OVER;
        end else if (clear_hit) begin
          if (phase_q == LAST_PHASE) begin
            state_d = S_CLEAR;
          end else if (TRANS_CYCLES == 0) begin
            phase_d = phase_q + 4'd1;
            timer_d = TIMER_PER_PHASE;
          end else begin
            state_d = S_TRANS;
            cnt_d   = CNT_W'(TRANS_CYCLES - 1);
          end
        end
      end
      S_TRANS: begin
        if (time_out) begin
          state_d = S_OVER;
        end else if (cnt_q == '0) begin
          state_d = S_PHASE;
          phase_d = phase_q + 4'd1;
          timer_d = TIMER_PER_PHASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CLEAR, S_OVER: begin
        if (start_pulse) begin
          state_d = S_IDLE;
          phase_d = 4'd0;
          stab_d  = STAB_INIT4;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    state_id = 4'd0;
    case (state_q)
      S_PHASE, S_TRANS: state_id = phase_q;
      S_CLEAR:          state_id = LAST_PHASE + 4'd1;
      S_OVER:           state_id = LAST_PHASE + 4'd2;
      default:          state_id = 4'd0;
    endcase
  end

  assign stability     = stab_q;
  assign game_enable   = (state_q == S_PHASE) && !(EVENT_FREEZE && event_active);
  assign timer_reset   = timer_q;
  assign game_clear    = (state_q == S_CLEAR);
  assign game_over     = (state_q == S_OVER);
  assign in_transition = (state_q == S_TRANS);

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Bench for game_phase_sequencer: directed scenarios on a default instance and a
// no-dwell / per-phase-timer / no-freeze instance, then random play against a game model.
module tb_game_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start_pulse, time_out, puzzle_fail, event_fail, recover, event_active;
  logic [3:0] phase_clear;

  logic [3:0] a_state_id, a_phase_onehot, a_stability;
  logic       a_game_enable, a_timer_reset, a_game_clear, a_game_over, a_in_transition;
  logic [3:0] b_state_id, b_phase_onehot, b_stability;
  logic       b_game_enable, b_timer_reset, b_game_clear, b_game_over, b_in_transition;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_phase_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .phase_clear(phase_clear),
    .time_out(time_out), .puzzle_fail(puzzle_fail), .event_fail(event_fail),
    .recover(recover), .event_active(event_active),
    .state_id(a_state_id), .phase_onehot(a_phase_onehot), .stability(a_stability),
    .game_enable(a_game_enable), .timer_reset(a_timer_reset), .game_clear(a_game_clear),
    .game_over(a_game_over), .in_transition(a_in_transition)
  );

  game_phase_sequencer #(
    .TRANS_CYCLES(0), .EVENT_FREEZE(1'b0), .TIMER_PER_PHASE(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .phase_clear(phase_clear),
    .time_out(time_out), .puzzle_fail(puzzle_fail), .event_fail(event_fail),
    .recover(recover), .event_active(event_active),
    .state_id(b_state_id), .phase_onehot(b_phase_onehot), .stability(b_stability),
    .game_enable(b_game_enable), .timer_reset(b_timer_reset), .game_clear(b_game_clear),
    .game_over(b_game_over), .in_transition(b_in_transition)
  );

  // Game model: mode of play, current phase, dwell cycles left, stability score.
  localparam int M_IDLE = 0, M_PLAY = 1, M_DWELL = 2, M_WON = 3, M_LOST = 4;
  int m_mode[2], m_phase[2], m_dwell[2], m_stab[2];
  bit m_tr[2];
  int p_trans[2] = '{3, 0};
  bit p_tpp[2]   = '{1'b0, 1'b1};
  bit p_frz[2]   = '{1'b1, 1'b0};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_mode[m] = M_IDLE; m_phase[m] = 0; m_dwell[m] = 0; m_stab[m] = 5; m_tr[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m);
    bit fl, rc;
    int ns;
    fl = puzzle_fail | event_fail;
    rc = recover;
    m_tr[m] = 1'b0;
    case (m_mode[m])
      M_IDLE: if (start_pulse) begin
        m_mode[m] = M_PLAY; m_phase[m] = 1; m_stab[m] = 5; m_tr[m] = 1'b1;
      end
      M_PLAY: begin
        ns = m_stab[m];
        if (fl && !rc) ns = (ns > 0) ? ns - 1 : 0;
        else if (rc && !fl) ns = (ns < 9) ? ns + 1 : 9;
        m_stab[m] = ns;
        if (time_out || (fl && !rc && ns == 0)) m_mode[m] = M_LOST;
        else if (phase_clear[m_phase[m]-1]) begin
          if (m_phase[m] == 4) m_mode[m] = M_WON;
          else if (p_trans[m] == 0) begin m_phase[m]++; m_tr[m] = p_tpp[m]; end
          else begin m_mode[m] = M_DWELL; m_dwell[m] = p_trans[m]; end
        end
      end
      M_DWELL: begin
        if (time_out) m_mode[m] = M_LOST;
        else begin
          m_dwell[m]--;
          if (m_dwell[m] == 0) begin m_mode[m] = M_PLAY; m_phase[m]++; m_tr[m] = p_tpp[m]; end
        end
      end
      default: if (start_pulse) begin
        m_mode[m] = M_IDLE; m_phase[m] = 0; m_stab[m] = 5;
      end
    endcase
  endtask

  function automatic logic [16:0] model_vec(input int m);
    logic [3:0] sid, oh;
    logic en;
    sid = 4'd0; oh = 4'd0;
    if (m_mode[m] == M_PLAY || m_mode[m] == M_DWELL) sid = 4'(m_phase[m]);
    if (m_mode[m] == M_WON) sid = 4'd5;
    if (m_mode[m] == M_LOST) sid = 4'd6;
    if (m_mode[m] == M_PLAY) oh = 4'(1 << (m_phase[m] - 1));
    en = (m_mode[m] == M_PLAY) && !(p_frz[m] && event_active);
    return {sid, oh, 4'(m_stab[m]), en, m_tr[m], m_mode[m] == M_WON, m_mode[m] == M_LOST,
            m_mode[m] == M_DWELL};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    checks++; if (a_state_id !== 4'd0) begin failures++; $display("FAIL reset_state_id: got %0d expected 0", a_state_id); end
    checks++; if (a_stability !== 4'd5) begin failures++; $display("FAIL reset_stability: got %0d expected 5", a_stability); end
    checks++; if (a_phase_onehot !== 4'd0) begin failures++; $display("FAIL reset_onehot: got %b expected 0000", a_phase_onehot); end
    checks++; if ({a_game_enable, a_timer_reset, a_game_clear, a_game_over, a_in_transition} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 00000",
        {a_game_enable, a_timer_reset, a_game_clear, a_game_over, a_in_transition}); end
    rst_n = 1'b1;
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_full_clear();
    int tcount, bcount, dwell;
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    checks++; if (a_state_id !== 4'd1) begin failures++; $display("FAIL start_state: got %0d expected 1", a_state_id); end
    tcount = int'(a_timer_reset);
    bcount = int'(b_timer_reset);
    for (int k = 0; k < 4; k++) begin
      phase_clear = 4'(1 << k); cyc(); phase_clear = 4'd0;
      tcount += int'(a_timer_reset); bcount += int'(b_timer_reset);
      dwell = 0;
      while (a_in_transition && dwell < 10) begin
        checks++; if (a_state_id !== 4'(k + 1)) begin failures++; $display("FAIL trans_state_id: got %0d expected %0d", a_state_id, k + 1); end
        dwell++; cyc();
        tcount += int'(a_timer_reset); bcount += int'(b_timer_reset);
      end
      checks++; if (dwell != ((k < 3) ? 3 : 0)) begin failures++; $display("FAIL trans_dwell: got %0d expected %0d", dwell, (k < 3) ? 3 : 0); end
      checks++; if (a_state_id !== 4'(k + 2)) begin failures++; $display("FAIL next_state_id: got %0d expected %0d", a_state_id, k + 2); end
    end
    checks++; if (a_game_clear !== 1'b1) begin failures++; $display("FAIL game_clear: got %b expected 1", a_game_clear); end
    checks++; if (tcount != 1) begin failures++; $display("FAIL timer_pulses: got %0d expected 1", tcount); end
    checks++; if (b_game_clear !== 1'b1) begin failures++; $display("FAIL b_game_clear: got %b expected 1", b_game_clear); end
    checks++; if (bcount != 4) begin failures++; $display("FAIL b_timer_pulses: got %0d expected 4", bcount); end
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    checks++; if (a_state_id !== 4'd0) begin failures++; $display("FAIL restart_idle: got %0d expected 0", a_state_id); end
    $display("test_full_clear done");
  endtask

  task automatic test_fail_chain();
    int guard;
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    phase_clear = 4'd1; cyc(); phase_clear = 4'd0;
    guard = 0;
    while (a_in_transition && guard < 10) begin guard++; cyc(); end
    checks++; if (a_state_id !== 4'd2 || a_stability !== 4'd5) begin failures++;
      $display("FAIL phase2_entry: got state %0d stab %0d expected state 2 stab 5", a_state_id, a_stability); end
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 1) event_fail = 1'b1; else puzzle_fail = 1'b1;
      cyc(); puzzle_fail = 1'b0; event_fail = 1'b0;
      checks++; if (a_stability !== 4'(4 - i)) begin failures++; $display("FAIL fail_stab: got %0d expected %0d", a_stability, 4 - i); end
    end
    checks++; if (a_state_id !== 4'd6 || a_game_over !== 1'b1) begin failures++;
      $display("FAIL stab_zero_over: got state %0d over %b expected state 6 over 1", a_state_id, a_game_over); end
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    checks++; if (a_state_id !== 4'd0 || a_stability !== 4'd5) begin failures++;
      $display("FAIL over_restart: got state %0d stab %0d expected state 0 stab 5", a_state_id, a_stability); end
    $display("test_fail_chain done");
  endtask

  task automatic test_stab_sat();
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    puzzle_fail = 1'b1; recover = 1'b1; cyc(); puzzle_fail = 1'b0;
    checks++; if (a_stability !== 4'd5) begin failures++; $display("FAIL fail_and_recover: got %0d expected 5", a_stability); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (a_stability !== 4'((i + 6 > 9) ? 9 : i + 6)) begin failures++;
        $display("FAIL recover_sat: got %0d expected %0d", a_stability, (i + 6 > 9) ? 9 : i + 6); end
    end
    recover = 1'b0;
    phase_clear = 4'd1; cyc(); phase_clear = 4'd0;
    puzzle_fail = 1'b1; cyc(); puzzle_fail = 1'b0;
    checks++; if (a_stability !== 4'd9 || a_in_transition !== 1'b1) begin failures++;
      $display("FAIL trans_fail_ignored: got stab %0d trans %b expected stab 9 trans 1", a_stability, a_in_transition); end
    time_out = 1'b1; cyc(); time_out = 1'b0;
    checks++; if (a_state_id !== 4'd6) begin failures++; $display("FAIL trans_timeout: got %0d expected 6", a_state_id); end
    puzzle_fail = 1'b1; cyc(); puzzle_fail = 1'b0;
    checks++; if (a_stability !== 4'd9) begin failures++; $display("FAIL over_fail_ignored: got %0d expected 9", a_stability); end
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    $display("test_stab_sat done");
  endtask

  task automatic test_priority();
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    phase_clear = 4'd1; time_out = 1'b1; cyc(); phase_clear = 4'd0; time_out = 1'b0;
    checks++; if (a_state_id !== 4'd6 || a_in_transition !== 1'b0) begin failures++;
      $display("FAIL timeout_priority: got state %0d trans %b expected state 6 trans 0", a_state_id, a_in_transition); end
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    $display("test_priority done");
  endtask

  task automatic test_event_freeze();
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    event_active = 1'b1; #1;
    checks++; if (a_game_enable !== 1'b0) begin failures++; $display("FAIL freeze_on: got %b expected 0", a_game_enable); end
    checks++; if (b_game_enable !== 1'b1) begin failures++; $display("FAIL freeze_off: got %b expected 1", b_game_enable); end
    event_active = 1'b0; #1;
    checks++; if (a_game_enable !== 1'b1) begin failures++; $display("FAIL enable_resume: got %b expected 1", a_game_enable); end
    time_out = 1'b1; cyc(); time_out = 1'b0;
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    $display("test_event_freeze done");
  endtask

  task automatic test_ignore_and_reset();
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    phase_clear = 4'b0100; cyc(); phase_clear = 4'd0;
    checks++; if (a_state_id !== 4'd1 || a_phase_onehot !== 4'b0001) begin failures++;
      $display("FAIL wrong_bit_ignored: got state %0d onehot %b expected state 1 onehot 0001", a_state_id, a_phase_onehot); end
    start_pulse = 1'b1; cyc(); start_pulse = 1'b0;
    checks++; if (a_state_id !== 4'd1 || a_timer_reset !== 1'b0) begin failures++;
      $display("FAIL start_in_phase: got state %0d timer %b expected state 1 timer 0", a_state_id, a_timer_reset); end
    phase_clear = 4'd1; cyc(); phase_clear = 4'd0;
    #2; rst_n = 1'b0; #1;
    checks++; if (a_state_id !== 4'd0 || a_stability !== 4'd5 || a_in_transition !== 1'b0) begin failures++;
      $display("FAIL async_reset: got state %0d stab %0d trans %b expected state 0 stab 5 trans 0",
        a_state_id, a_stability, a_in_transition); end
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(); cyc();
    checks++; if (a_state_id !== 4'd0) begin failures++; $display("FAIL needs_start: got %0d expected 0", a_state_id); end
    $display("test_ignore_and_reset done");
  endtask

  task automatic test_random();
    logic [16:0] exp_a, exp_b, act_a, act_b;
    int games;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    model_reset();
    games = 0;
    for (int n = 0; n < 3000; n++) begin
      start_pulse  = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < 4; b++) phase_clear[b] = ($urandom_range(0, 9) < 3);
      time_out     = ($urandom_range(0, 59) == 0);
      puzzle_fail  = ($urandom_range(0, 9) == 0);
      event_fail   = ($urandom_range(0, 19) == 0);
      recover      = ($urandom_range(0, 7) == 0);
      event_active = ($urandom_range(0, 9) < 3);
      #1;
      exp_a = model_vec(0); exp_b = model_vec(1);
      act_a = {a_state_id, a_phase_onehot, a_stability, a_game_enable, a_timer_reset,
               a_game_clear, a_game_over, a_in_transition};
      act_b = {b_state_id, b_phase_onehot, b_stability, b_game_enable, b_timer_reset,
               b_game_clear, b_game_over, b_in_transition};
      checks++; if (act_a !== exp_a) begin failures++; $display("FAIL random_a cycle %0d: got %h expected %h", n, act_a, exp_a); end
      checks++; if (act_b !== exp_b) begin failures++; $display("FAIL random_b cycle %0d: got %h expected %h", n, act_b, exp_b); end
      @(posedge clk);
      if (m_mode[0] == M_IDLE && start_pulse) games++;
      model_step(0); model_step(1);
      #1;
    end
    start_pulse = 1'b0; phase_clear = 4'd0; time_out = 1'b0;
    puzzle_fail = 1'b0; event_fail = 1'b0; recover = 1'b0; event_active = 1'b0;
    $display("test_random done: %0d games started", games);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_pulse = 1'b0; phase_clear = 4'd0; time_out = 1'b0;
    puzzle_fail = 1'b0; event_fail = 1'b0; recover = 1'b0; event_active = 1'b0;
    #1;
    test_reset();
    test_full_clear();
    test_fail_chain();
    test_stab_sat();
    test_priority();
    test_event_freeze();
    test_ignore_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
